// File: rtl/idli_fetch_sqi.sv
`default_nettype none
// ============================================================================
// idli_fetch_sqi - drives two SQI memories in quad read and rebuilds 16-bit words
// Revision: 1.0
// ============================================================================
module idli_fetch_sqi #(
  parameter logic [7:0]  SQI_CMD_READ = 8'h03,
  parameter int unsigned SQI_DUMMY    = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic            o_sqi_cs_n,
  output logic            o_sqi_sck_en,
  output logic            o_sqi_oe,
  output logic [3:0]      o_sqi_data,
  input  logic [1:0][3:0] i_sqi_data,
  input  logic            i_redirect,
  input  logic [15:0]     i_redirect_pc,
  output logic            o_instr_vld,
  output logic [15:0]     o_instr,
  output logic [15:0]     o_instr_pc,
  input  logic            i_instr_rdy
);

  localparam logic SQI_MEM_LO = 1'b0;
  localparam logic SQI_MEM_HI = 1'b1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CMD   = 3'd1;
  localparam logic [2:0] ST_ADDR  = 3'd2;
  localparam logic [2:0] ST_DUMMY = 3'd3;
  localparam logic [2:0] ST_DATA  = 3'd4;

  localparam logic [7:0] CMD_LAST   = 8'd1;
  localparam logic [7:0] ADDR_LAST  = 8'd5;
  localparam logic [7:0] DUMMY_LAST = (SQI_DUMMY == 0) ? 8'd0 : 8'(SQI_DUMMY - 1);
  // A zero-dummy configuration goes straight from address to data.
  localparam logic [2:0] ST_AFTER_ADDR = (SQI_DUMMY == 0) ? ST_DATA : ST_DUMMY;

  logic [2:0]  state;
  logic [7:0]  cnt;
  logic        half;
  logic [15:0] fetch_pc;
  logic [7:0]  staging;

  logic        in_data;
  logic        stall;
  logic        load;
  logic        transfer;
  logic [23:0] addr;
  logic [3:0]  addr_nib;
  logic [7:0]  beat_byte;

  assign in_data   = (state == ST_DATA);
  assign stall     = in_data && half && o_instr_vld && !i_instr_rdy;
  assign load      = in_data && half && !stall;
  assign transfer  = o_instr_vld && i_instr_rdy;
  assign addr      = {8'h00, fetch_pc};
  assign beat_byte = {i_sqi_data[SQI_MEM_HI], i_sqi_data[SQI_MEM_LO]};

  always_comb begin
    addr_nib = addr[23:20];
    case (cnt[2:0])
      3'd0:    addr_nib = addr[23:20];
      3'd1:    addr_nib = addr[19:16];
      3'd2:    addr_nib = addr[15:12];
      3'd3:    addr_nib = addr[11:8];
      3'd4:    addr_nib = addr[7:4];
      3'd5:    addr_nib = addr[3:0];
      default: addr_nib = addr[23:20];
    endcase
  end

  always_comb begin
    o_sqi_cs_n   = 1'b1;
    o_sqi_sck_en = 1'b0;
    o_sqi_oe     = 1'b0;
    o_sqi_data   = 4'h0;
    case (state)
      ST_CMD: begin
        o_sqi_cs_n   = 1'b0;
        o_sqi_sck_en = 1'b1;
        o_sqi_oe     = 1'b1;
        o_sqi_data   = (cnt == 8'd0) ? SQI_CMD_READ[7:4] : SQI_CMD_READ[3:0];
      end
      ST_ADDR: begin
        o_sqi_cs_n   = 1'b0;
        o_sqi_sck_en = 1'b1;
        o_sqi_oe     = 1'b1;
        o_sqi_data   = addr_nib;
      end
      ST_DUMMY: begin
        o_sqi_cs_n   = 1'b0;
        o_sqi_sck_en = 1'b1;
      end
      ST_DATA: begin
        o_sqi_cs_n   = 1'b0;
        o_sqi_sck_en = !stall;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      cnt         <= 8'd0;
      half        <= 1'b0;
      fetch_pc    <= 16'h0000;
      staging     <= 8'h00;
      o_instr_vld <= 1'b0;
      o_instr     <= 16'h0000;
      o_instr_pc  <= 16'h0000;
    end else if (i_redirect) begin
      // Held or in-flight words are dropped even if the decoder is accepting.
      state       <= ST_IDLE;
      cnt         <= 8'd0;
      half        <= 1'b0;
      fetch_pc    <= i_redirect_pc;
      o_instr_vld <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_CMD;
          cnt   <= 8'd0;
        end
        ST_CMD: begin
          if (cnt == CMD_LAST) begin
            state <= ST_ADDR;
            cnt   <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_ADDR: begin
          if (cnt == ADDR_LAST) begin
            state <= ST_AFTER_ADDR;
            cnt   <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_DUMMY: begin
          if (cnt == DUMMY_LAST) begin
            state <= ST_DATA;
            cnt   <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_DATA: begin
          if (!stall) begin
            if (!half) begin
              staging <= beat_byte;
              half    <= 1'b1;
            end else begin
              o_instr    <= {beat_byte, staging};
              o_instr_pc <= fetch_pc;
              fetch_pc   <= fetch_pc + 16'd1;
              half       <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (load) begin
        o_instr_vld <= 1'b1;
      end else if (transfer) begin
        o_instr_vld <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_idli_fetch_sqi.sv
`default_nettype none
// tb_idli_fetch_sqi: dual SQI memory model with a word scoreboard for idli_fetch_sqi.
module tb_idli_fetch_sqi;
  localparam int DUMMY = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            redirect = 1'b0;
  logic [15:0]     redirect_pc = 16'h0000;
  logic            rdy = 1'b0;
  logic            cs_n, sck_en, oe, vld;
  logic [3:0]      sqi_out;
  logic [1:0][3:0] sqi_in;
  logic [15:0]     instr, instr_pc;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [15:0] sb_pc[$];
  logic [15:0] sb_word[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  idli_fetch_sqi #(.SQI_CMD_READ(8'h03), .SQI_DUMMY(DUMMY)) dut (
    .i_clk(clk), .i_rst(rst),
    .o_sqi_cs_n(cs_n), .o_sqi_sck_en(sck_en), .o_sqi_oe(oe), .o_sqi_data(sqi_out),
    .i_sqi_data(sqi_in),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_instr_vld(vld), .o_instr(instr), .o_instr_pc(instr_pc),
    .i_instr_rdy(rdy)
  );

  // Memory contents: one byte per word address, emitted MSB nibble first.
  function automatic logic [7:0] mem_lo(input logic [15:0] a);
    if (a == 16'h0000) return 8'h12;
    return (a[7:0] * 8'd7) ^ a[15:8] ^ 8'h35;
  endfunction

  function automatic logic [7:0] mem_hi(input logic [15:0] a);
    if (a == 16'h0000) return 8'hAB;
    return ~a[7:0] + a[15:8] + 8'h19;
  endfunction

  function automatic logic [15:0] exp_word(input logic [15:0] a);
    logic [7:0] lo, hi;
    lo = mem_lo(a);
    hi = mem_hi(a);
    return {hi[3:0], lo[3:0], hi[7:4], lo[7:4]};
  endfunction

  task automatic sb_restart(input logic [15:0] pc, input int n);
    sb_pc.delete();
    sb_word.delete();
    for (int i = 0; i < n; i++) begin
      sb_pc.push_back(pc + 16'(i));
      sb_word.push_back(exp_word(pc + 16'(i)));
    end
  endtask

  // SQI memory pair: counts SCK beats while selected.
  int unsigned mnib = 0;
  logic [23:0] maddr = 24'h0;
  always @(posedge clk) begin
    if (cs_n) begin
      mnib <= 0;
    end else if (sck_en) begin
      mnib <= mnib + 1;
      if (mnib >= 2 && mnib < 8) maddr <= {maddr[19:0], sqi_out};
    end
  end

  int unsigned m_k;
  logic [15:0] m_a;
  logic [7:0]  m_lo, m_hi;
  always_comb begin
    m_k = 0;
    m_a = 16'h0;
    m_lo = 8'h0;
    m_hi = 8'h0;
    sqi_in = '0;
    if (!cs_n && mnib >= 8 + DUMMY) begin
      m_k = mnib - 8 - DUMMY;
      m_a = maddr[15:0] + 16'(m_k / 2);
      m_lo = mem_lo(m_a);
      m_hi = mem_hi(m_a);
      sqi_in[0] = m_k[0] ? m_lo[3:0] : m_lo[7:4];
      sqi_in[1] = m_k[0] ? m_hi[3:0] : m_hi[7:4];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; rdy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({cs_n, sck_en, oe, sqi_out} !== 7'b1000000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 1000000", {cs_n, sck_en, oe, sqi_out});
    end
    n_checks++;
    if ({vld, instr, instr_pc} !== 33'h0) begin
      n_fail++; $display("FAIL reset_instr: got vld=%b instr=%h pc=%h want 0/0000/0000", vld, instr, instr_pc);
    end
  endtask

  task automatic test_reset_fetch();
    logic [3:0] nib [8];
    nib = '{4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    step();
    rst = 1'b0; rdy = 1'b0;
    sb_restart(16'h0000, 12);
    for (int c = 0; c <= 13; c++) begin
      @(negedge clk);
      n_checks++;
      if (c == 0) begin
        if ({cs_n, sck_en, oe} !== 3'b100) begin
          n_fail++; $display("FAIL rf_idle c%0d: got %b want 100", c, {cs_n, sck_en, oe});
        end
      end else if (c <= 8) begin
        if ({cs_n, sck_en, oe, sqi_out} !== {3'b011, nib[c-1]}) begin
          n_fail++; $display("FAIL rf_cmdaddr c%0d: got %b want %b", c, {cs_n, sck_en, oe, sqi_out}, {3'b011, nib[c-1]});
        end
      end else begin
        if ({cs_n, sck_en, oe, sqi_out} !== 7'b0100000) begin
          n_fail++; $display("FAIL rf_dummydata c%0d: got %b want 0100000", c, {cs_n, sck_en, oe, sqi_out});
        end
      end
      n_checks++;
      if (vld !== (c == 13)) begin
        n_fail++; $display("FAIL rf_vld c%0d: got %b want %b", c, vld, (c == 13));
      end
      if (c == 13) begin
        n_checks++;
        if ({instr, instr_pc} !== {16'hB2A1, 16'h0000}) begin
          n_fail++; $display("FAIL rf_word: got %h pc %h want b2a1 pc 0000", instr, instr_pc);
        end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int got, last;
    logic [15:0] e_pc, e_w;
    for (int c = 14; c <= 17; c++) begin
      @(negedge clk);
      n_checks++;
      if ({vld, instr_pc, instr} !== {1'b1, sb_pc[0], sb_word[0]}) begin
        n_fail++; $display("FAIL bp_hold c%0d: got %b %h %h want 1 %h %h", c, vld, instr_pc, instr, sb_pc[0], sb_word[0]);
      end
      n_checks++;
      if (sck_en !== 1'b0) begin
        n_fail++; $display("FAIL bp_stall_sck c%0d: got %b want 0", c, sck_en);
      end
      step();
    end
    rdy = 1'b1;
    got = 0; last = 0;
    for (int c = 0; c < 30 && got < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (sck_en !== 1'b1) begin
        n_fail++; $display("FAIL bp_sck_run: got %b want 1", sck_en);
      end
      if (vld && rdy) begin
        n_checks++;
        if (sb_pc.size() == 0) begin
          n_fail++; $display("FAIL bp_extra_word: got pc %h want none", instr_pc);
        end else begin
          e_pc = sb_pc.pop_front(); e_w = sb_word.pop_front();
          if ({instr_pc, instr} !== {e_pc, e_w}) begin
            n_fail++; $display("FAIL bp_word: got pc %h %h want pc %h %h", instr_pc, instr, e_pc, e_w);
          end
        end
        if (got >= 2) begin
          n_checks++;
          if (cyc - last != 2) begin
            n_fail++; $display("FAIL bp_gap: got %0d want 2", cyc - last);
          end
        end
        last = cyc; got++;
      end
      step();
    end
    n_checks++;
    if (got != 4) begin
      n_fail++; $display("FAIL bp_count: got %0d want 4", got);
    end
  endtask

  task automatic test_streaming();
    int got, last;
    logic [15:0] e_pc, e_w;
    rdy = 1'b1; redirect = 1'b1; redirect_pc = 16'h0000;
    sb_restart(16'h0000, 8);
    step();
    redirect = 1'b0;
    got = 0; last = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      if (got > 0) begin
        n_checks++;
        if (sck_en !== 1'b1) begin
          n_fail++; $display("FAIL st_sck: got %b want 1", sck_en);
        end
      end
      if (vld && rdy) begin
        n_checks++;
        e_pc = sb_pc.pop_front(); e_w = sb_word.pop_front();
        if ({instr_pc, instr} !== {e_pc, e_w}) begin
          n_fail++; $display("FAIL st_word: got pc %h %h want pc %h %h", instr_pc, instr, e_pc, e_w);
        end
        if (got > 0) begin
          n_checks++;
          if (cyc - last != 2) begin
            n_fail++; $display("FAIL st_gap: got %0d want 2", cyc - last);
          end
        end
        last = cyc; got++;
      end
      step();
    end
    n_checks++;
    if (got != 4) begin
      n_fail++; $display("FAIL st_count: got %0d want 4", got);
    end
  endtask

  task automatic test_redirect_addr();
    logic [3:0] nib [8];
    logic [15:0] e_pc, e_w;
    nib = '{4'h0, 4'h3, 4'h0, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4};
    rdy = 1'b1; redirect = 1'b1; redirect_pc = 16'h0040;
    step();
    redirect = 1'b0;
    repeat (5) step();
    @(negedge clk);
    n_checks++;
    if ({cs_n, oe} !== 2'b01) begin
      n_fail++; $display("FAIL ra_in_addr: got %b want 01", {cs_n, oe});
    end
    step();
    redirect = 1'b1; redirect_pc = 16'h1234;
    sb_restart(16'h1234, 4);
    step();
    redirect = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_checks++;
        if ({cs_n, sck_en, oe} !== 3'b100) begin
          n_fail++; $display("FAIL ra_idle: got %b want 100", {cs_n, sck_en, oe});
        end
      end else if (k <= 9) begin
        n_checks++;
        if ({cs_n, sck_en, oe, sqi_out} !== {3'b011, nib[k-2]}) begin
          n_fail++; $display("FAIL ra_nib k%0d: got %b want %b", k, {cs_n, sck_en, oe, sqi_out}, {3'b011, nib[k-2]});
        end
      end
      n_checks++;
      if (vld !== (k == 14)) begin
        n_fail++; $display("FAIL ra_vld k%0d: got %b want %b", k, vld, (k == 14));
      end
      if (k == 14) begin
        n_checks++;
        e_pc = sb_pc.pop_front(); e_w = sb_word.pop_front();
        if ({instr_pc, instr} !== {e_pc, e_w}) begin
          n_fail++; $display("FAIL ra_word: got pc %h %h want pc %h %h", instr_pc, instr, e_pc, e_w);
        end
      end
      step();
    end
  endtask

  task automatic test_redirect_held();
    bit found;
    int got, n0;
    logic [15:0] e_pc, e_w;
    rdy = 1'b0; found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (vld) found = 1'b1;
      else step();
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL rh_no_word: got vld 0 want 1 within 40 cycles");
    end
    step();
    rdy = 1'b1; redirect = 1'b1; redirect_pc = 16'h0200;
    sb_restart(16'h0200, 4);
    n0 = cyc;
    @(negedge clk);
    n_checks++;
    if (vld !== 1'b1) begin
      n_fail++; $display("FAIL rh_held: got %b want 1", vld);
    end
    step();
    redirect = 1'b0;
    @(negedge clk);
    n_checks++;
    if (vld !== 1'b0) begin
      n_fail++; $display("FAIL rh_vld_clear: got %b want 0", vld);
    end
    step();
    got = 0;
    for (int c = 0; c < 30 && got < 2; c++) begin
      @(negedge clk);
      if (vld && rdy) begin
        n_checks++;
        e_pc = sb_pc.pop_front(); e_w = sb_word.pop_front();
        if ({instr_pc, instr} !== {e_pc, e_w}) begin
          n_fail++; $display("FAIL rh_word: got pc %h %h want pc %h %h", instr_pc, instr, e_pc, e_w);
        end
        if (got == 0) begin
          n_checks++;
          if (cyc - n0 != 14) begin
            n_fail++; $display("FAIL rh_latency: got %0d want 14", cyc - n0);
          end
        end
        got++;
      end
      step();
    end
    n_checks++;
    if (got != 2) begin
      n_fail++; $display("FAIL rh_count: got %0d want 2", got);
    end
  endtask

  task automatic test_wrap_reset();
    int got;
    logic [15:0] e_pc, e_w;
    rdy = 1'b1; redirect = 1'b1; redirect_pc = 16'hFFFF;
    sb_restart(16'hFFFF, 4);
    step();
    redirect = 1'b0;
    got = 0;
    for (int c = 0; c < 40 && got < 2; c++) begin
      @(negedge clk);
      if (vld && rdy) begin
        n_checks++;
        e_pc = sb_pc.pop_front(); e_w = sb_word.pop_front();
        if ({instr_pc, instr} !== {e_pc, e_w}) begin
          n_fail++; $display("FAIL wr_word: got pc %h %h want pc %h %h", instr_pc, instr, e_pc, e_w);
        end
        got++;
      end
      step();
    end
    n_checks++;
    if (got != 2) begin
      n_fail++; $display("FAIL wr_count: got %0d want 2", got);
    end
    // Reset and redirect together mid-DATA: reset must win.
    rst = 1'b1; redirect = 1'b1; redirect_pc = 16'h5555;
    step();
    rst = 1'b0; redirect = 1'b0; rdy = 1'b0;
    sb_restart(16'h0000, 2);
    for (int k = 0; k <= 13; k++) begin
      @(negedge clk);
      if (k == 0) begin
        n_checks++;
        if ({cs_n, sck_en, oe, sqi_out} !== 7'b1000000) begin
          n_fail++; $display("FAIL wr_rst_ctrl: got %b want 1000000", {cs_n, sck_en, oe, sqi_out});
        end
        n_checks++;
        if ({vld, instr, instr_pc} !== 33'h0) begin
          n_fail++; $display("FAIL wr_rst_instr: got vld=%b instr=%h pc=%h want 0/0000/0000", vld, instr, instr_pc);
        end
      end
      n_checks++;
      if (vld !== (k == 13)) begin
        n_fail++; $display("FAIL wr_vld k%0d: got %b want %b", k, vld, (k == 13));
      end
      if (k == 13) begin
        n_checks++;
        if ({instr_pc, instr} !== {sb_pc[0], sb_word[0]}) begin
          n_fail++; $display("FAIL wr_restart_word: got pc %h %h want pc %h %h", instr_pc, instr, sb_pc[0], sb_word[0]);
        end
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_reset_fetch();
    test_backpressure();
    test_streaming();
    test_redirect_addr();
    test_redirect_held();
    test_wrap_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
